// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier and the
// gate-level arithmetic blocks it reuses.
package seq_multiplier_pkg;

  // Operand width used when the instantiating design does not override it.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Control states; the unused code 2'd3 is steered back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_adder.sv
// Gate library primitives and the ripple-carry adder built only from them.
// The adder has no arithmetic operators so it can be shared with the
// sequential divider later on.

// Two-input AND.
module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule : and_gate

// Two-input OR.
module or_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule : or_gate

// Two-input XOR.
module xor_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ^ b_i;
endmodule : xor_gate

// One-bit full adder: propagate/generate form, 2 XOR + 2 AND + 1 OR.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p;  // propagate
  logic g;  // generate
  logic t;  // carry passed through by propagate

  xor_gate u_xor_p (.a_i(x),   .b_i(y),   .y_o(p));
  xor_gate u_xor_s (.a_i(p),   .b_i(cin), .y_o(s));
  and_gate u_and_g (.a_i(x),   .b_i(y),   .y_o(g));
  and_gate u_and_t (.a_i(p),   .b_i(cin), .y_o(t));
  or_gate  u_or_co (.a_i(g),   .b_i(t),   .y_o(co));
endmodule : full_adder

// WIDTH-bit ripple-carry adder: s = x + y + cin, carry-out on co.
module ripple_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign co       = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .cin(carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end
endmodule : ripple_adder

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier. One add/shift step per cycle for WIDTH
// cycles, then a single DONE cycle in which the registered product and the
// done pulse are presented together.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q;        // multiplicand
  logic [WIDTH-1:0]   a_q;        // accumulator, high half of the product
  logic [WIDTH-1:0]   q_q;        // multiplier, shifts into the low half
  logic               c_q;        // carry into the adder, cleared every step
  logic [CNT_W-1:0]   cnt_q;      // steps remaining after the current one
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   addend;     // M gated by the current multiplier bit
  logic [WIDTH-1:0]   sum;
  logic               co;

  // Select M or zero with AND gates keyed by the multiplier LSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_gate_m
    and_gate u_and_m (.a_i(m_q[i]), .b_i(q_q[0]), .y_o(addend[i]));
  end

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .x  (a_q),
    .y  (addend),
    .cin(c_q),
    .s  (sum),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    // NOTE: assign a default first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, add/shift datapath, step counter and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset, so an aborted operation never
    // leaves a stale product visible after reset.
    if (!rst_n) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q   <= a;
            q_q   <= b;
            a_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= CNT_W'(WIDTH - 1);
          end
        end
        S_RUN: begin
          // {C,A,Q} <= {co,sum,Q} >> 1
          a_q <= {co, sum[WIDTH-1:1]};
          q_q <= {sum[0], q_q[WIDTH-1:1]};
          c_q <= 1'b0;
          if (cnt_q == '0) begin
            // Capture the final shifted value so it is valid with done.
            product_q <= {co, sum, q_q[WIDTH-1:1]};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH = 4, 8 and 16. Expected
// products come from plain integer multiplication of the operands the bench
// presented on the accepting edge.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 8 instance (main)
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;
  // WIDTH = 4 instance
  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  product4;
  // WIDTH = 16 instance
  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] product16;

  int n_cmp = 0;
  int n_bad = 0;
  bit overlap_seen = 1'b0;
  bit long_done_seen = 1'b0;
  logic [2:0] done_prev = 3'b000;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  // Watch all instances for busy/done overlap and done longer than a cycle.
  always @(negedge clk) begin
    if ((busy && done) || (busy4 && done4) || (busy16 && done16))
      overlap_seen = 1'b1;
    if ((done && done_prev[0]) || (done4 && done_prev[1]) || (done16 && done_prev[2]))
      long_done_seen = 1'b1;
    done_prev = {done16, done4, done};
  end

  function automatic logic dn(input int w);
    case (w)
      4:       return done4;
      16:      return done16;
      default: return done;
    endcase
  endfunction

  function automatic logic bz(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy;
    endcase
  endfunction

  function automatic logic [31:0] pr(input int w);
    case (w)
      4:       return {24'd0, product4};
      16:      return product16;
      default: return {16'd0, product};
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [15:0] x, input logic [15:0] y);
    case (w)
      4:       begin start4  = s; a4  = x[3:0]; b4  = y[3:0]; end
      16:      begin start16 = s; a16 = x;      b16 = y;      end
      default: begin start   = s; a   = x[7:0]; b   = y[7:0]; end
    endcase
  endtask

  // One operation: present operands for one edge, scramble them during the
  // run, measure cycles to done and cycles with busy; return in IDLE.
  task automatic do_op(input int w, input logic [15:0] x, input logic [15:0] y,
                       output logic [31:0] p, output int lat, output int bcyc);
    @(negedge clk);
    drive(w, 1'b1, x, y);
    @(negedge clk);
    drive(w, 1'b0, 16'($urandom), 16'($urandom));
    lat  = 1;
    bcyc = 0;
    while (!dn(w) && lat < 60) begin
      if (bz(w)) bcyc++;
      @(negedge clk);
      drive(w, 1'b0, 16'($urandom), 16'($urandom));
      lat++;
    end
    p = pr(w);
    if (!dn(w)) lat = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int widths[3] = '{4, 8, 16};
    #1;
    foreach (widths[i]) begin
      n_cmp++;
      if (bz(widths[i]) !== 1'b0 || dn(widths[i]) !== 1'b0 || pr(widths[i]) !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_w%0d: busy=%b done=%b product=%0d, required 0/0/0",
                 widths[i], bz(widths[i]), dn(widths[i]), pr(widths[i]));
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] xs[6] = '{16'd13, 16'd255, 16'd0,   16'd200, 16'd1, 16'd128};
    logic [15:0] ys[6] = '{16'd11, 16'd255, 16'd200, 16'd0,   16'd1, 16'd2};
    logic [31:0] p, exp;
    int lat, bcyc;
    foreach (xs[i]) begin
      do_op(8, xs[i], ys[i], p, lat, bcyc);
      exp = 32'(xs[i]) * 32'(ys[i]);
      n_cmp++;
      if (p !== exp) begin
        n_bad++;
        $display("FAIL directed_product %0d*%0d: got %0d, required %0d", xs[i], ys[i], p, exp);
      end
      n_cmp++;
      if (lat != 9 || bcyc != 8) begin
        n_bad++;
        $display("FAIL directed_timing %0d*%0d: latency %0d busy %0d, required 9 and 8",
                 xs[i], ys[i], lat, bcyc);
      end
    end
  endtask

  // start held high: accepts land every 10 edges; operands change every cycle.
  task automatic test_back_to_back();
    logic [7:0] ra[31], rb[31];
    logic [15:0] exp;
    int ph;
    foreach (ra[i]) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b1; a = ra[0]; b = rb[0];
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ph = c % 10;
      n_cmp++;
      if (busy !== (ph < 8) || done !== (ph == 8)) begin
        n_bad++;
        $display("FAIL b2b_handshake edge %0d: busy=%b done=%b, required %b/%b",
                 c, busy, done, (ph < 8), (ph == 8));
      end
      if (ph == 8) begin
        exp = 16'(ra[c-8]) * 16'(rb[c-8]);
        n_cmp++;
        if (product !== exp) begin
          n_bad++;
          $display("FAIL b2b_product op %0d: got %0d, required %0d", c / 10, product, exp);
        end
      end
      if (c < 29) begin
        a = ra[c+1];
        b = rb[c+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p;
    int lat, bcyc;
    bit done_after = 1'b0;
    do_op(8, 16'd200, 16'd3, p, lat, bcyc);  // leaves a nonzero product
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);  // now in RUN cycle 4
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%0d, required 0/0/0",
               busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) done_after = 1'b1;
    end
    n_cmp++;
    if (done_after !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_no_done: done seen after abort=%b, required 0", done_after);
    end
    do_op(8, 16'd7, 16'd9, p, lat, bcyc);
    n_cmp++;
    if (p !== 32'd63 || lat != 9) begin
      n_bad++;
      $display("FAIL midrun_recover: product %0d latency %0d, required 63 and 9", p, lat);
    end
  endtask

  task automatic test_random(input int w, input int n);
    logic [15:0] msk, x, y;
    logic [31:0] p, exp;
    int lat, bcyc;
    msk = 16'((32'd1 << w) - 1);
    for (int i = 0; i < n; i++) begin
      x = 16'($urandom) & msk;
      y = 16'($urandom) & msk;
      if (i == 0) begin x = msk; y = msk; end
      do_op(w, x, y, p, lat, bcyc);
      exp = 32'(x) * 32'(y);
      n_cmp++;
      if (p !== exp || lat != w + 1 || bcyc != w) begin
        n_bad++;
        $display("FAIL random_w%0d %0d*%0d: product %0d latency %0d busy %0d, required %0d, %0d, %0d",
                 w, x, y, p, lat, bcyc, exp, w + 1, w);
      end
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (overlap_seen !== 1'b0 || long_done_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_exclusive: overlap=%b long_done=%b, required 0/0",
               overlap_seen, long_done_seen);
    end
  endtask

  initial begin
    start = 1'b0;   a = '0;   b = '0;
    start4 = 1'b0;  a4 = '0;  b4 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random(8, 1000);
    test_random(4, 300);
    test_random(16, 300);
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_multiplier
